fpdiv_arbiter: RTL and testbench

- Shares one floating-point divider wrapper (53-bit significand, 11-bit exponent, sign, 3-bit flags per operand) between two requesters.
- Accepts packed operand bundles on two valid/ready request ports and picks one per operation by round-robin.
- Issues a single-cycle start to the divider, holds operands stable until finished, then returns the result on the winner's response port.
- A watchdog recovers a hung divider.

---
 rtl/fpdiv_pkg.sv | 30 +++
 rtl/fpdiv_arbiter_if.sv | 46 ++++
 rtl/fpdiv_rr_pick.sv | 13 +
 rtl/fpdiv_arbiter.sv | 141 ++++++++++++++
 tb/tb_fpdiv_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the two-requester floating-point divider arbiter.
// Bundle field offsets assume the default significand/exponent widths.
package fpdiv_pkg;

    localparam int unsigned DEF_INT_W = 53;
    localparam int unsigned DEF_EXP_W = 11;

    // Bundle layout MSB..LSB: inputA, inputB, expA, expB, sgnA, sgnB, mode, flgA, flgB
    localparam int unsigned FLGB_OFF = 0;
    localparam int unsigned FLGA_OFF = 3;
    localparam int unsigned MODE_OFF = 6;
    localparam int unsigned SGNB_OFF = 7;
    localparam int unsigned SGNA_OFF = 8;
    localparam int unsigned EXPB_OFF = 9;
    localparam int unsigned EXPA_OFF = EXPB_OFF + DEF_EXP_W;
    localparam int unsigned INB_OFF  = EXPA_OFF + DEF_EXP_W;
    localparam int unsigned INA_OFF  = INB_OFF + DEF_INT_W;

    localparam logic [2:0] FLG_NORMAL = 3'b001;
    localparam logic [2:0] FLG_ZERO   = 3'b010;
    localparam logic [2:0] FLG_INF    = 3'b011;
    localparam logic [2:0] FLG_NAN    = 3'b100;

    function automatic int unsigned op_w(int unsigned int_w, int unsigned exp_w);
        return 2 * int_w + 2 * exp_w + 9;
    endfunction

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

endpackage

// File: rtl/fpdiv_arbiter_if.sv
// Request/response and divider-side signals of the divider arbiter.
// The slave modport is the arbiter; master is the surrounding requesters and divider.
interface fpdiv_arbiter_if #(
    parameter int unsigned INT_W = fpdiv_pkg::DEF_INT_W,
    parameter int unsigned EXP_W = fpdiv_pkg::DEF_EXP_W,
    parameter int unsigned OP_W  = fpdiv_pkg::op_w(INT_W, EXP_W)
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OP_W-1:0] req0_op;
    logic            req1_valid;
    logic            req1_ready;
    logic [OP_W-1:0] req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [INT_W-1:0] rsp_res;
    logic [EXP_W-1:0] rsp_exp;
    logic             rsp_sgn;
    logic             rsp_err;

    logic             div_rst;
    logic             div_start;
    logic [OP_W-1:0]  div_op;
    logic [INT_W-1:0] div_res;
    logic [EXP_W-1:0] div_exp;
    logic             div_sgn;
    logic             div_finished;

    modport slave (
        input  req0_valid, req0_op, req1_valid, req1_op, rsp0_ready, rsp1_ready,
        input  div_res, div_exp, div_sgn, div_finished,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_res, rsp_exp, rsp_sgn, rsp_err, div_rst, div_start, div_op
    );

    modport master (
        output req0_valid, req0_op, req1_valid, req1_op, rsp0_ready, rsp1_ready,
        output div_res, div_exp, div_sgn, div_finished,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_res, rsp_exp, rsp_sgn, rsp_err, div_rst, div_start, div_op
    );

endinterface

// File: rtl/fpdiv_rr_pick.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to rr_ptr.
module fpdiv_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = valid0 | valid1;
    assign gnt_id    = (valid0 && valid1) ? rr_ptr : valid1;

endmodule

// File: rtl/fpdiv_arbiter.sv
// Shares one floating-point divider between two requesters, round-robin per operation,
// with a watchdog that aborts and resets a divider that never finishes.
module fpdiv_arbiter
    import fpdiv_pkg::*;
#(
    parameter int unsigned INT_W   = DEF_INT_W,
    parameter int unsigned EXP_W   = DEF_EXP_W,
    parameter int unsigned TIMEOUT = 127,
    parameter int unsigned OP_W    = op_w(INT_W, EXP_W)
) (
    input logic            clk,
    input logic            rst,
    fpdiv_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             gnt_id_q, gnt_id_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [INT_W-1:0] res_q, res_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sgn_q, sgn_d;
    logic             err_q, err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             abort_q, abort_d;

    logic pick_valid, pick_id;
    logic ready0, ready1, start, valid0, valid1, rsp_take;

    fpdiv_rr_pick u_pick (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (pick_valid),
        .gnt_id    (pick_id)
    );

    assign rsp_take = gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        op_d     = op_q;
        res_d    = res_q;
        exp_d    = exp_q;
        sgn_d    = sgn_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        abort_d  = 1'b0;
        ready0   = 1'b0;
        ready1   = 1'b0;
        start    = 1'b0;
        valid0   = 1'b0;
        valid1   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid && !rst) begin
                    ready0   = ~pick_id;
                    ready1   = pick_id;
                    op_d     = pick_id ? bus.req1_op : bus.req0_op;
                    gnt_id_d = pick_id;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                start   = ~rst;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // cnt_q == 0 is the first WAIT cycle; a done level there may be stale
                if (bus.div_finished && cnt_q != '0) begin
                    res_d   = bus.div_res;
                    exp_d   = bus.div_exp;
                    sgn_d   = bus.div_sgn;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    exp_d   = '0;
                    sgn_d   = 1'b0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                valid0 = ~gnt_id_q & ~rst;
                valid1 = gnt_id_q & ~rst;
                if (rsp_take) begin
                    rr_ptr_d = ~gnt_id_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= 1'b0;
            gnt_id_q <= 1'b0;
            op_q     <= '0;
            res_q    <= '0;
            exp_q    <= '0;
            sgn_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            op_q     <= op_d;
            res_q    <= res_d;
            exp_q    <= exp_d;
            sgn_q    <= sgn_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = valid0;
    assign bus.rsp1_valid = valid1;
    assign bus.rsp_res    = res_q;
    assign bus.rsp_exp    = exp_q;
    assign bus.rsp_sgn    = sgn_q;
    assign bus.rsp_err    = err_q;
    assign bus.div_start  = start;
    assign bus.div_op     = op_q;
    assign bus.div_rst    = rst | abort_q;

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Scoreboard bench for fpdiv_arbiter: a driver feeds queued requests, a monitor
// checks every response handshake against expected results pushed at grant time.
module tb_fpdiv_arbiter;
    import fpdiv_pkg::*;

    localparam int unsigned IW = DEF_INT_W;
    localparam int unsigned EW = DEF_EXP_W;
    localparam int unsigned OW = op_w(IW, EW);
    localparam int unsigned TO = 127;

    localparam int MNormal = 0;
    localparam int MHang   = 1;
    localparam int MStale  = 2;

    typedef struct {
        logic [OW-1:0] op;
        logic          port;
        logic [IW-1:0] res;
        logic [EW-1:0] ex;
        logic          sgn;
        logic          err;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpdiv_arbiter_if #(.INT_W(IW), .EXP_W(EW)) bus ();

    fpdiv_arbiter #(.INT_W(IW), .EXP_W(EW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    cyc = 0;
    int    n_checks = 0;
    int    n_err = 0;
    int    mode = MNormal;
    int    since = 0;
    item_t pend0[$];
    item_t pend1[$];
    item_t exp_q[$];
    int    grant_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: quotient significand = inputA, exponent = expA, sign = sgnA ^ sgnB.
    // 'since' is 1 in the first WAIT cycle after start.
    always @(posedge clk) begin
        if (bus.div_rst) since <= 0;
        else if (bus.div_start) since <= 1;
        else if (since != 0 && since < 1000) since <= since + 1;
    end

    always_comb begin
        bus.div_finished = 1'b0;
        case (mode)
            MHang:   bus.div_finished = 1'b0;
            MStale:  bus.div_finished = bus.div_start || since == 1 || since >= 4;
            default: bus.div_finished = since >= 5;
        endcase
    end

    assign bus.div_res = bus.div_op[INA_OFF +: IW];
    assign bus.div_exp = bus.div_op[EXPA_OFF +: EW];
    assign bus.div_sgn = bus.div_op[SGNA_OFF] ^ bus.div_op[SGNB_OFF];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic item_t mk_item(input logic port, input logic [IW-1:0] a,
                                      input logic [IW-1:0] b, input logic [EW-1:0] ea,
                                      input logic [EW-1:0] eb, input logic sa, input logic sb,
                                      input logic [2:0] fa, input logic [2:0] fb);
        item_t it;
        it.op   = {a, b, ea, eb, sa, sb, 1'b0, fa, fb};
        it.port = port;
        it.res  = a;
        it.ex   = ea;
        it.sgn  = sa ^ sb;
        it.err  = 1'b0;
        return it;
    endfunction

    // Request driver: presents the head of each pending queue, records grants.
    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op    = '0;
        bus.req1_op    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.req0_valid && bus.req0_ready) begin
                    exp_q.push_back(pend0[0]);
                    grant_log.push_back(0);
                    void'(pend0.pop_front());
                end
                if (bus.req1_valid && bus.req1_ready) begin
                    exp_q.push_back(pend1[0]);
                    grant_log.push_back(1);
                    void'(pend1.pop_front());
                end
            end
            @(posedge clk);
            #1;
            bus.req0_valid = pend0.size() != 0;
            if (pend0.size() != 0) bus.req0_op = pend0[0].op;
            bus.req1_valid = pend1.size() != 0;
            if (pend1.size() != 0) bus.req1_op = pend1[0].op;
        end
    end

    // Monitor: start timing/operand after each grant, and every response handshake.
    initial begin
        logic          hs_pending;
        int            hs_cyc;
        logic [OW-1:0] hs_op;
        item_t         e;
        hs_pending = 1'b0;
        hs_cyc     = 0;
        hs_op      = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.req0_valid && bus.req0_ready) begin
                    hs_pending = 1'b1;
                    hs_cyc     = cyc;
                    hs_op      = bus.req0_op;
                end else if (bus.req1_valid && bus.req1_ready) begin
                    hs_pending = 1'b1;
                    hs_cyc     = cyc;
                    hs_op      = bus.req1_op;
                end
                if (bus.div_start) begin
                    chk("start_after_grant", {63'd0, hs_pending}, 64'd1);
                    chk("start_latency", 64'(cyc - hs_cyc), 64'd1);
                    chk("start_operand", 64'(bus.div_op != hs_op), 64'd0);
                    hs_pending = 1'b0;
                end
                if (bus.rsp0_valid || bus.rsp1_valid)
                    chk("rsp_exclusive", {63'd0, bus.rsp0_valid && bus.rsp1_valid}, 64'd0);
                if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_port", {63'd0, bus.rsp1_valid}, {63'd0, e.port});
                        chk("rsp_res", 64'(bus.rsp_res), 64'(e.res));
                        chk("rsp_exp", 64'(bus.rsp_exp), 64'(e.ex));
                        chk("rsp_sgn", {63'd0, bus.rsp_sgn}, {63'd0, e.sgn});
                        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
                        chk("op_held", 64'(bus.div_op != e.op), 64'd0);
                    end
                end
            end
        end
    end

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.div_start) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) chk("start_seen", 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input int budget, output int c, output logic early_rst);
        c         = -1;
        early_rst = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                c = cyc;
                break;
            end
            if (bus.div_rst) early_rst = 1'b1;
        end
        if (c < 0) chk("rsp_seen", 64'd0, 64'd1);
    endtask

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pend0.size() == 0 && pend1.size() == 0 && exp_q.size() == 0 &&
                !bus.rsp0_valid && !bus.rsp1_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int            s;
        int            c;
        logic          early;
        int            seen;
        item_t         it;
        logic [IW-1:0] held_res;

        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_div_rst", {63'd0, bus.div_rst}, 64'd1);
        chk("rst_start", {63'd0, bus.div_start}, 64'd0);
        chk("rst_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_div_rst", {63'd0, bus.div_rst}, 64'd0);
        chk("rel_div_op", 64'(bus.div_op != '0), 64'd0);
        chk("rel_rsp_res", 64'(bus.rsp_res), 64'd0);
        chk("rel_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        chk("rel_req0_ready", {63'd0, bus.req0_ready}, 64'd0);

        // Single op on requester 0: finishes 5 cycles after start
        pend0.push_back(mk_item(1'b0, 53'h10_0000_0000_0000, 53'h0_8000_0000_0000, 11'h3FF,
                                11'h400, 1'b1, 1'b0, FLG_NORMAL, FLG_NORMAL));
        wait_start(s);
        wait_valid(40, c, early);
        chk("single_latency", 64'(c - s), 64'd6);
        drain(40);

        // Reset while in WAIT: operation dropped, no response
        pend0.push_back(mk_item(1'b0, 53'h1_2345, 53'h6789, 11'h012, 11'h034, 1'b0, 1'b0,
                                FLG_ZERO, FLG_NORMAL));
        wait_start(s);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("wait_rst_div_rst", {63'd0, bus.div_rst}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("wait_rst_div_op", 64'(bus.div_op != '0), 64'd0);
        chk("wait_rst_start", {63'd0, bus.div_start}, 64'd0);
        chk("wait_rst_div_rst_low", {63'd0, bus.div_rst}, 64'd0);
        chk("wait_rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp0_valid || bus.rsp1_valid) seen++;
            @(negedge clk);
        end
        chk("wait_rst_no_rsp", 64'(seen), 64'd0);

        // Both requesters valid every cycle: grants alternate from requester 0
        grant_log.delete();
        pend0.push_back(mk_item(1'b0, 53'hA1, 53'h1, 11'h101, 11'h1, 1'b0, 1'b1,
                                FLG_NORMAL, FLG_INF));
        pend0.push_back(mk_item(1'b0, 53'hA2, 53'h2, 11'h102, 11'h2, 1'b1, 1'b1,
                                FLG_NAN, FLG_NORMAL));
        pend1.push_back(mk_item(1'b1, 53'hB1, 53'h3, 11'h201, 11'h3, 1'b1, 1'b0,
                                FLG_NORMAL, FLG_ZERO));
        pend1.push_back(mk_item(1'b1, 53'hB2, 53'h4, 11'h202, 11'h4, 1'b0, 1'b0,
                                FLG_INF, FLG_NAN));
        drain(120);
        chk("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            chk("rr_order0", 64'(grant_log[0]), 64'd0);
            chk("rr_order1", 64'(grant_log[1]), 64'd1);
            chk("rr_order2", 64'(grant_log[2]), 64'd0);
            chk("rr_order3", 64'(grant_log[3]), 64'd1);
        end

        // Backpressure on requester 1's response
        bus.rsp1_ready = 1'b0;
        pend1.push_back(mk_item(1'b1, 53'h1F_FFFF_0000_1234, 53'h5, 11'h7FE, 11'h5, 1'b1,
                                1'b0, FLG_NORMAL, FLG_NORMAL));
        wait_valid(40, c, early);
        held_res = bus.rsp_res;
        pend0.push_back(mk_item(1'b0, 53'hC3, 53'h6, 11'h303, 11'h6, 1'b0, 1'b1,
                                FLG_NORMAL, FLG_NORMAL));
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {63'd0, bus.rsp1_valid}, 64'd1);
            chk("bp_res", 64'(bus.rsp_res), 64'(53'h1F_FFFF_0000_1234));
            chk("bp_res_stable", 64'(bus.rsp_res != held_res), 64'd0);
            chk("bp_req0_ready", {63'd0, bus.req0_ready}, 64'd0);
            @(posedge clk);
        end
        #1 bus.rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_last", {63'd0, bus.rsp1_valid}, 64'd1);
        drain(60);

        // Hung divider: watchdog fires after 127 WAIT cycles
        mode = MHang;
        it = mk_item(1'b0, 53'hDEAD, 53'hBEEF, 11'h111, 11'h222, 1'b1, 1'b0,
                     FLG_NORMAL, FLG_NORMAL);
        it.res = '0;
        it.ex  = '0;
        it.sgn = 1'b0;
        it.err = 1'b1;
        pend0.push_back(it);
        wait_start(s);
        wait_valid(200, c, early);
        chk("hang_latency", 64'(c - s), 64'(TO + 1));
        chk("hang_no_early_rst", {63'd0, early}, 64'd0);
        chk("hang_div_rst", {63'd0, bus.div_rst}, 64'd1);
        @(negedge clk);
        chk("hang_div_rst_pulse", {63'd0, bus.div_rst}, 64'd0);
        mode = MNormal;
        pend1.push_back(mk_item(1'b1, 53'h77, 53'h8, 11'h0AA, 11'h8, 1'b0, 1'b1,
                                FLG_NORMAL, FLG_NORMAL));
        drain(60);

        // Stale done during LAUNCH and first WAIT cycle; real done at WAIT cycle 4
        mode = MStale;
        pend1.push_back(mk_item(1'b1, 53'h5A5A, 53'h9, 11'h055, 11'h9, 1'b1, 1'b1,
                                FLG_NORMAL, FLG_NORMAL));
        wait_start(s);
        wait_valid(40, c, early);
        chk("stale_latency", 64'(c - s), 64'd5);
        drain(40);
        mode = MNormal;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
